// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data-memory responder.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/dmem_sram_array.sv
// dmem_sram_array: word-addressed storage with byte-strobed writes and a read register on the same enable.
module dmem_sram_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    input  logic [WORD_BYTES-1:0]          wstrb,
    output logic [31:0]                    rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < WORD_BYTES; i++)
                if (we && wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready load/store responder with fixed latency over word-addressed storage.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    dmem_state_t state, state_nx;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_wstrb;
    logic        addr_err, access, rd_ok, err_q;
    logic [31:0] sram_rdata;

    assign addr_err = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(DEPTH_WORDS));
    // gating on rst keeps a store that is pending at reset from reaching storage
    assign access   = (state == WAIT) && (cnt == 4'd0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_valid) state_nx = WAIT;
            WAIT:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !rst;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            rd_ok <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                err_q <= addr_err;
                rd_ok <= !lat_we && !addr_err;
            end
        end
    end

    dmem_sram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
        .clk   (clk),
        .en    (access),
        .we    (lat_we && !addr_err),
        .addr  (lat_addr[AW+1:2]),
        .wdata (lat_wdata),
        .wstrb (lat_wstrb),
        .rdata (sram_rdata)
    );

    assign rsp_rdata = (rsp_valid && rd_ok) ? sram_rdata : 32'd0;
    assign rsp_err   = rsp_valid && err_q;
endmodule
